cen_phase_gen: RTL and testbench
================================

# cen_phase_gen

Parametrised fractional clock-enable generator. Generalises the fixed PLL output set (one fast system clock plus three equal-rate, quarter-period-staggered pixel clocks) into NUM_CH phase-staggered clock-enable pulses derived from the single system clock. The rate (num/den) and the per-channel phase offsets can be reprogrammed at runtime through a valid/ready config port, and a lock indicator is provided. The block sits beside the core PLL and drives video and CPU `cen` inputs, so no extra PLL outputs are needed.

## Interface
- NUM_CH, 3, number of enable channels
- CW, 16, width of num/den/accumulator
- OFS_W, 8, width of each per-channel phase offset (system-clock cycles)
- LOCK_TICKS, 4, base ticks required after (re)start before `locked` asserts
- DEF_NUM, 1, reset-value numerator
- DEF_DEN, 8, reset-value denominator (53.6 MHz / 8 = 6.7 MHz)
- DEF_OFS, {8'd4,8'd2,8'd0}, reset-value packed offsets; channel k occupies bits [k*OFS_W +: OFS_W]

Ports:
- clk  in  1  system clock; single clock domain
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  run request; low stops generation
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  configuration can be accepted
- cfg_num  in  CW  rate numerator
- cfg_den  in  CW  rate denominator
- cfg_ofs  in  NUM_CH*OFS_W  packed per-channel offsets
- cfg_err  out  1  one-cycle pulse when an offered configuration is rejected
- cen  out  NUM_CH  per-channel one-cycle clock-enable pulses
- locked  out  1  generation is stable

## Operation
- Reset (reset_n low at a clk edge): num=DEF_NUM, den=DEF_DEN, ofs=DEF_OFS, acc=0, channel counters idle, lock count=0, state STOP. All outputs are 0. cfg_ready is 1 from the first cycle after release.
- States:
  - STOP: acc is held at 0, no ticks. Goes to LOCKING when enable=1.
  - LOCKING: accumulating. Goes to LOCKED after LOCK_TICKS ticks.
  - Any state goes to STOP when enable=0.
  - Config accept goes to LOCKING if enable=1, otherwise STOP.
- Accumulator: sum = acc + num, computed in CW+1 bits. If sum >= den then tick=1 and acc <= sum - den; otherwise acc <= sum. Average tick rate is num/den of clk.
- Channels: on a tick, channel k loads its countdown with ofs_k. cen[k] pulses exactly once, in cycle t+1+ofs_k for a tick in cycle t.
  - If a channel fires in the same cycle a new tick reloads it, the fire is emitted and the reload also takes effect.
- Config handshake: a config is accepted when cfg_valid && cfg_ready. cfg_ready=1 at all times after reset.
- Validity check. A config is valid iff num != 0 AND den != 0 AND num <= den AND (ofs_k+1)*num <= den for every k. The last condition guarantees ofs_k < minimum tick period.
- Valid accept:
  - Latch num/den/ofs.
  - Clear acc, channel counters and lock count.
  - locked and cen go 0 from the next cycle.
  - Generation restarts from acc=0.
- Invalid accept: cfg_err pulses high the next cycle for one cycle. The previous configuration and all running state are untouched.
- enable=0: cen forced 0 and locked=0 from the next cycle; acc, counters and lock count cleared. Latched config is retained.
- If a config accept and enable=0 occur in the same cycle, the config is latched and the state becomes STOP.
- locked rises the cycle after the LOCK_TICKS-th tick. It stays high until a config accept, enable=0, or reset.

## Timing
- All outputs are registered. cfg_err and cen are single-cycle pulses.
- With num=1, den=8, default offsets, and enable rising so that cycle 0 is the first LOCKING cycle with acc=0:
  - ticks occur at cycles 7, 15, 23, 31, …
  - cen[0] pulses at 8, 16, …; cen[1] at 10, 18, …; cen[2] at 12, 20, …
  - locked rises at cycle 32.
- Fractional rates give a tick spacing of floor(den/num) or ceil(den/num), with no long-term drift: exactly num ticks per den cycles.
- Reset asserted mid-operation takes effect at the next edge, regardless of pending fires.

## Test plan
- Defaults: release reset, enable=1 → cen[0]/cen[1]/cen[2] every 8 cycles at offsets 0/2/4 after tick+1; locked rises at cycle 32.
- Fractional: num=3, den=8, offsets 0,1,1 → exactly 300 pulses on cen[0] in 800 cycles; spacing only 2 or 3; locked after 4 ticks.
- Invalid configs:
  - num=0 → cfg_err pulse, old cadence continues unchanged.
  - den=4, num=1, ofs=4 → cfg_err pulse, old cadence continues unchanged.
  - num=9, den=8 → cfg_err pulse, old cadence continues unchanged.
- Reconfig while LOCKED: num=1, den=4, offsets 0,1,2 → locked drops next cycle; first tick 3 cycles after accept; new cadence; locked after 4 new ticks.
- Boundary offset: num=1, den=4, ofs_2=3 → cen[2] coincides with the reload cycle; each tick yields exactly one cen[2] pulse, none lost or duplicated.
- enable drop mid-period plus simultaneous config accept, then reset mid-run → cen and locked are 0 next cycle; the new config takes effect on re-enable; reset returns DEF_* behaviour.

Source files
------------

// File: rtl/cen_phase_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : cen_phase_gen_if
// Description : Runtime configuration port for cen_phase_gen. It carries
//               the rate numerator and denominator, plus the packed
//               per-channel phase offsets, over a valid/ready handshake.
//               It also returns a reject pulse.
//   master : drives cfg_valid, cfg_num, cfg_den, cfg_ofs;
//            receives cfg_ready, cfg_err
//   slave  : the generator side (mirror of master)
// Revision    : 1.0 - initial release
// ============================================================================
interface cen_phase_gen_if #(
  parameter int NUM_CH = 3,
  parameter int CW     = 16,
  parameter int OFS_W  = 8
);
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [CW-1:0]           cfg_num;
  logic [CW-1:0]           cfg_den;
  logic [NUM_CH*OFS_W-1:0] cfg_ofs;
  logic                    cfg_err;

  modport master (
    output cfg_valid, cfg_num, cfg_den, cfg_ofs,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_num, cfg_den, cfg_ofs,
    output cfg_ready, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/cen_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : cen_phase_gen
// Description : Fractional clock-enable generator. A num/den phase
//               accumulator produces base ticks. Each tick launches
//               NUM_CH single-cycle cen pulses, each delayed by a
//               programmable per-channel offset. A lock flag rises
//               after LOCK_TICKS ticks.
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   enable   in   run request; low stops and clears generation
//   cfg      slave  configuration handshake (num/den/ofs, ready, err)
//   cen      out  NUM_CH one-cycle enable pulses
//   locked   out  generation stable
// Revision    : 1.0 - initial release
// ============================================================================
module cen_phase_gen #(
  parameter int                      NUM_CH     = 3,
  parameter int                      CW         = 16,
  parameter int                      OFS_W      = 8,
  parameter int                      LOCK_TICKS = 4,
  parameter logic [CW-1:0]           DEF_NUM    = 16'd1,
  parameter logic [CW-1:0]           DEF_DEN    = 16'd8,
  parameter logic [NUM_CH*OFS_W-1:0] DEF_OFS    = {8'd4, 8'd2, 8'd0}
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              enable,
  cen_phase_gen_if.slave         cfg,
  output logic [NUM_CH-1:0]      cen,
  output logic                   locked
);

  localparam logic [1:0] ST_STOP    = 2'd0;
  localparam logic [1:0] ST_LOCKING = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam int LW = (LOCK_TICKS > 1) ? $clog2(LOCK_TICKS) : 1;
  localparam int PW = CW + OFS_W + 1;

  logic [1:0]                    r_state;
  logic [CW-1:0]                 r_num;
  logic [CW-1:0]                 r_den;
  logic [NUM_CH*OFS_W-1:0]       r_ofs;
  logic [CW-1:0]                 r_acc;
  logic [NUM_CH-1:0]             r_pend;
  logic [NUM_CH-1:0][OFS_W-1:0]  r_cnt;
  logic [LW-1:0]                 r_lock_cnt;
  logic [NUM_CH-1:0]             r_cen;
  logic                          r_locked;
  logic                          r_err;
  logic                          r_ready;

  logic [CW:0]                   w_sum;
  logic                          w_tick;
  logic [CW-1:0]                 w_acc_next;
  logic [NUM_CH-1:0]             w_ch_ok;
  logic                          w_cfg_ok;
  logic                          w_accept;

  // Phase accumulator; the extra sum bit keeps acc+num from wrapping.
  always_comb begin
    w_sum      = {1'b0, r_acc} + {1'b0, r_num};
    w_tick     = (r_state != ST_STOP) && (w_sum >= {1'b0, r_den});
    w_acc_next = w_tick ? CW'(w_sum - {1'b0, r_den}) : w_sum[CW-1:0];
  end

  // (ofs_k+1)*num <= den keeps every channel's delay shorter than the
  // shortest tick spacing. The channel then fires before its next reload.
  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_chk
      logic [PW-1:0] w_prod;
      assign w_prod     = (PW'(cfg.cfg_ofs[k*OFS_W +: OFS_W]) + PW'(1)) * PW'(cfg.cfg_num);
      assign w_ch_ok[k] = (w_prod <= PW'(cfg.cfg_den));
    end
  endgenerate

  assign w_cfg_ok = (cfg.cfg_num != '0) && (cfg.cfg_den != '0) &&
                    (cfg.cfg_num <= cfg.cfg_den) && (&w_ch_ok);
  assign w_accept = cfg.cfg_valid && r_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_STOP;
      r_num      <= DEF_NUM;
      r_den      <= DEF_DEN;
      r_ofs      <= DEF_OFS;
      r_acc      <= '0;
      r_pend     <= '0;
      r_cnt      <= '0;
      r_lock_cnt <= '0;
      r_cen      <= '0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_err   <= w_accept && !w_cfg_ok;
      r_cen   <= '0;
      if (w_accept && w_cfg_ok) begin
        // A new configuration restarts generation from a clean phase.
        r_num      <= cfg.cfg_num;
        r_den      <= cfg.cfg_den;
        r_ofs      <= cfg.cfg_ofs;
        r_acc      <= '0;
        r_pend     <= '0;
        r_lock_cnt <= '0;
        r_locked   <= 1'b0;
        r_state    <= enable ? ST_LOCKING : ST_STOP;
      end else if (!enable) begin
        r_acc      <= '0;
        r_pend     <= '0;
        r_lock_cnt <= '0;
        r_locked   <= 1'b0;
        r_state    <= ST_STOP;
      end else if (r_state == ST_STOP) begin
        r_state <= ST_LOCKING;
      end else begin
        r_acc <= w_acc_next;
        for (int k = 0; k < NUM_CH; k++) begin
          if (r_pend[k]) begin
            if (r_cnt[k] == '0) begin
              r_cen[k]  <= 1'b1;
              r_pend[k] <= 1'b0;
            end else begin
              r_cnt[k] <= r_cnt[k] - OFS_W'(1);
            end
          end
          // A reload issued in the same cycle as a fire overrides the
          // pending clear above, so both the fire and the reload are kept.
          if (w_tick) begin
            if (r_ofs[k*OFS_W +: OFS_W] == '0) begin
              r_cen[k] <= 1'b1;
            end else begin
              r_pend[k] <= 1'b1;
              r_cnt[k]  <= r_ofs[k*OFS_W +: OFS_W] - OFS_W'(1);
            end
          end
        end
        if (w_tick && (r_state == ST_LOCKING)) begin
          if (r_lock_cnt == LW'(LOCK_TICKS - 1)) begin
            r_state  <= ST_LOCKED;
            r_locked <= 1'b1;
          end else begin
            r_lock_cnt <= r_lock_cnt + LW'(1);
          end
        end
      end
    end
  end

  assign cfg.cfg_ready = r_ready;
  assign cfg.cfg_err   = r_err;
  assign cen           = r_cen;
  assign locked        = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_cen_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_cen_phase_gen
// Description : Self-checking bench for cen_phase_gen. The reference model
//               tracks the index n of the current cycle within a run.
//               Tick m is present iff floor((m+1)num/den) > floor(m num/den).
//               cen[k] follows tick n-1-ofs_k, and locked means
//               floor(n num/den) >= LOCK_TICKS.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cen_phase_gen;

  localparam int NUM_CH     = 3;
  localparam int CW         = 16;
  localparam int OFS_W      = 8;
  localparam int LOCK_TICKS = 4;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic [NUM_CH-1:0] cen;
  logic              locked;

  cen_phase_gen_if #(.NUM_CH(NUM_CH), .CW(CW), .OFS_W(OFS_W)) bus ();

  cen_phase_gen dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .cfg     (bus),
    .cen     (cen),
    .locked  (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  longint m_num, m_den, m_seg;
  longint m_ofs [NUM_CH];
  bit     m_ready, m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit cfg_ok(longint n, longint d, logic [NUM_CH*OFS_W-1:0] o);
    if (n == 0 || d == 0 || n > d) return 1'b0;
    for (int k = 0; k < NUM_CH; k++)
      if ((longint'(o[k*OFS_W +: OFS_W]) + 1) * n > d) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit tick_at(longint m);
    return ((m + 1) * m_num / m_den) != (m * m_num / m_den);
  endfunction

  task automatic model_edge();
    bit acc_v, ok;
    if (!reset_n) begin
      m_num = 1; m_den = 8; m_ofs[0] = 0; m_ofs[1] = 2; m_ofs[2] = 4;
      m_seg = -1; m_ready = 1'b0; m_err = 1'b0;
    end else begin
      acc_v = bus.cfg_valid && m_ready;
      ok    = cfg_ok(longint'(bus.cfg_num), longint'(bus.cfg_den), bus.cfg_ofs);
      m_err = acc_v && !ok;
      if (acc_v && ok) begin
        m_num = longint'(bus.cfg_num);
        m_den = longint'(bus.cfg_den);
        for (int k = 0; k < NUM_CH; k++) m_ofs[k] = longint'(bus.cfg_ofs[k*OFS_W +: OFS_W]);
        m_seg = enable ? 0 : -1;
      end else if (!enable) begin
        m_seg = -1;
      end else if (m_seg < 0) begin
        m_seg = 0;
      end else begin
        m_seg++;
      end
      m_ready = 1'b1;
    end
  endtask

  task automatic check_outputs();
    logic [NUM_CH-1:0] e_cen;
    logic              e_lock;
    for (int k = 0; k < NUM_CH; k++) begin
      longint m;
      m = m_seg - 1 - m_ofs[k];
      e_cen[k] = (m_seg >= 0 && m >= 0) ? tick_at(m) : 1'b0;
    end
    e_lock = (m_seg >= 0) && ((m_seg * m_num / m_den) >= LOCK_TICKS);
    chk("cen",       64'(cen),           64'(e_cen));
    chk("locked",    64'(locked),        64'(e_lock));
    chk("cfg_err",   64'(bus.cfg_err),   64'(m_err));
    chk("cfg_ready", 64'(bus.cfg_ready), 64'(m_ready));
  endtask

  // One clock: model follows the edge, outputs are checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic offer(input int n, input int d, input int o0, input int o1, input int o2);
    bus.cfg_valid = 1'b1;
    bus.cfg_num   = CW'(n);
    bus.cfg_den   = CW'(d);
    bus.cfg_ofs   = {OFS_W'(o2), OFS_W'(o1), OFS_W'(o0)};
    step();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int first_lock, pulses, last, gap_ok;
    reset_n = 1'b0; enable = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_num = '0; bus.cfg_den = '0; bus.cfg_ofs = '0;
    m_num = 1; m_den = 8; m_seg = -1; m_ready = 1'b0; m_err = 1'b0;
    for (int k = 0; k < NUM_CH; k++) m_ofs[k] = 0;
    run(3);

    // Defaults: release and enable; this edge enters run cycle 0.
    reset_n = 1'b1; enable = 1'b1;
    step();
    first_lock = -1;
    for (int i = 1; i <= 45; i++) begin
      step();
      if (locked === 1'b1 && first_lock < 0) first_lock = i;
    end
    chk("default_lock_cycle", 64'(first_lock), 64'(32));

    // Fractional 3/8, offsets 0,1,1: 300 pulses in 800 cycles, gaps of 2 or 3.
    offer(3, 8, 0, 1, 1);
    pulses = 0; last = -1; gap_ok = 1;
    for (int i = 1; i <= 800; i++) begin
      step();
      if (cen[0] === 1'b1) begin
        pulses++;
        if (last >= 0 && (i - last) != 2 && (i - last) != 3) gap_ok = 0;
        last = i;
      end
    end
    chk("frac_pulses", 64'(pulses), 64'(300));
    chk("frac_spacing", 64'(gap_ok), 64'(1));

    // Invalid offers; the model keeps the old cadence running.
    offer(0, 8, 0, 1, 1);  run(20);
    offer(1, 4, 4, 0, 0);  run(20);
    offer(9, 8, 0, 0, 0);  run(20);

    // Reconfigure while locked.
    offer(1, 4, 0, 1, 2);  run(40);

    // Boundary offset: ofs_2 = 3 at den/num = 4.
    offer(1, 4, 0, 1, 3);
    pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (cen[2] === 1'b1) pulses++;
    end
    chk("boundary_cen2_pulses", 64'(pulses), 64'(9));

    // Randomized configurations and enable levels.
    for (int it = 0; it < 12; it++) begin
      int n, d;
      n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 6));
      d = int'($urandom_range(1, 20));
      enable = ($urandom_range(0, 4) != 0);
      offer(n, d, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      run(int'($urandom_range(20, 60)));
    end

    // Make sure the run is locked, then drop enable together with an accept.
    enable = 1'b1;
    offer(1, 8, 0, 2, 4);  run(40);
    enable = 1'b0;
    offer(1, 5, 1, 2, 3);  run(6);
    enable = 1'b1;         run(40);

    // Reset mid-run, then return to default behaviour.
    run(3);
    reset_n = 1'b0;        step();
    reset_n = 1'b1;        run(45);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
